micro_sequencer: RTL and testbench

- Parametrised microprogram address sequencer; the next generation of the 4-bit Am2909 slice used in the family.
- Address width and stack depth are parameters, so one instance replaces a cascade of slices.
- Adds asynchronous reset, stack FULL/EMPTY/ERR flags, carry-out for cascading, and an optional loop counter.
- Sits between the microinstruction pipeline register and the control store address bus.

---
 rtl/micro_sequencer.sv | 144 ++++++++++++++
 tb/tb_micro_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Parametrised microprogram address sequencer (Am2909 successor) with stack flags and carry-out.
// Optional AR loop-counter mode is enabled by defining MSEQ_LOOP_COUNTER_EN.
module micro_sequencer #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 5
) (
  input  logic             CP,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] OR,
  input  logic [1:0]       S,
  input  logic             FE,
  input  logic             PUP,
  input  logic             RE,
  input  logic             OE,
  input  logic             ZERO,
  input  logic             C,
  output logic [WIDTH-1:0] Y,
  output logic             COUT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             ERR,
  input  logic             CNT_DEC,
  output logic             CNT_ZERO
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] upc_r;
  logic [WIDTH-1:0] ar_r;
  logic [WIDTH-1:0] stack_r [DEPTH];
  logic [CW-1:0]    count_r;
  logic             err_r;
  logic             full_s;
  logic             empty_s;
  logic [WIDTH-1:0] top_s;
  logic [WIDTH-1:0] mux_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH:0]   sum_s;

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});

  // Top-of-stack read; an empty stack reads as zero.
  always_comb begin
    top_s = {WIDTH{1'b0}};
    if (empty_s) begin
      top_s = {WIDTH{1'b0}};
    end else begin
      top_s = stack_r[IW'(count_r - CW'(1))];
    end
  end

  // Source select, zero force and OR merge forming the next address.
  always_comb begin
    mux_s = {WIDTH{1'b0}};
    case (S)
      2'b00:   mux_s = upc_r;
      2'b01:   mux_s = ar_r;
      2'b10:   mux_s = top_s;
      2'b11:   mux_s = D;
      default: mux_s = {WIDTH{1'b0}};
    endcase
    if (!ZERO) begin
      a_s = {WIDTH{1'b0}};
    end else begin
      a_s = mux_s | OR;
    end
  end

  assign sum_s = {1'b0, a_s} + {{WIDTH{1'b0}}, C};
  assign COUT  = sum_s[WIDTH];
  assign Y     = OE ? {WIDTH{1'bz}} : a_s;
  assign FULL  = full_s;
  assign EMPTY = empty_s;
  assign ERR   = err_r;

  // Microprogram counter always takes the incremented address.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      upc_r <= {WIDTH{1'b0}};
    end else begin
      upc_r <= sum_s[WIDTH-1:0];
    end
  end

  // Return stack: push saves the pre-edge uPC; misuse sets the sticky error.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      count_r <= {CW{1'b0}};
      err_r   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_r[i] <= {WIDTH{1'b0}};
      end
    end else if (!FE) begin
      if (PUP) begin
        if (!full_s) begin
          stack_r[IW'(count_r)] <= upc_r;
          count_r               <= count_r + CW'(1);
        end else begin
          err_r <= 1'b1;
        end
      end else begin
        if (!empty_s) begin
          count_r <= count_r - CW'(1);
        end else begin
          err_r <= 1'b1;
        end
      end
    end
  end

`ifdef MSEQ_LOOP_COUNTER_EN
  // Address register doubling as a saturating loop counter; load has priority.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      ar_r <= {WIDTH{1'b0}};
    end else if (!RE) begin
      ar_r <= R;
    end else if (CNT_DEC && (ar_r != {WIDTH{1'b0}})) begin
      ar_r <= ar_r - WIDTH'(1);
    end
  end

  assign CNT_ZERO = (ar_r == {WIDTH{1'b0}});
`else
  logic unused_cnt_dec_s;

  // Plain address register.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      ar_r <= {WIDTH{1'b0}};
    end else if (!RE) begin
      ar_r <= R;
    end
  end

  assign unused_cnt_dec_s = CNT_DEC;
  assign CNT_ZERO         = 1'b0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus randomized
// stimulus compared against a queue-based behavioural model.
module tb_micro_sequencer;

  localparam int WIDTH = 12;
  localparam int DEPTH = 5;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             cp = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] d, r, orin;
  logic [1:0]       s;
  logic             fe, pup, re, oe, zero, c, cnt_dec;
  logic [WIDTH-1:0] y;
  logic             cout, full, empty, err, cnt_zero;

  micro_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CP(cp), .RST(rst), .D(d), .R(r), .OR(orin), .S(s), .FE(fe), .PUP(pup),
    .RE(re), .OE(oe), .ZERO(zero), .C(c), .Y(y), .COUT(cout), .FULL(full),
    .EMPTY(empty), .ERR(err), .CNT_DEC(cnt_dec), .CNT_ZERO(cnt_zero)
  );

  always #5 cp = ~cp;

  int passed = 0;
  int total  = 0;

  int m_upc, m_ar, m_err;
  int m_stk[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int model_a();
    int mux;
    case (s)
      2'd0:    mux = m_upc;
      2'd1:    mux = m_ar;
      2'd2:    mux = (m_stk.size() == 0) ? 0 : m_stk[m_stk.size() - 1];
      default: mux = int'(d);
    endcase
    return zero ? (mux | int'(orin)) : 0;
  endfunction

  task automatic model_reset();
    m_upc = 0; m_ar = 0; m_err = 0;
    m_stk.delete();
  endtask

  task automatic check_outs();
    int a;
    a = model_a();
    if (!oe) check_eq("y", int'(y), a);
    check_eq("cout", int'(cout), (c && a == MAXV) ? 1 : 0);
    check_eq("full", int'(full), (m_stk.size() == DEPTH) ? 1 : 0);
    check_eq("empty", int'(empty), (m_stk.size() == 0) ? 1 : 0);
    check_eq("err", int'(err), m_err);
`ifdef MSEQ_LOOP_COUNTER_EN
    check_eq("cnt_zero", int'(cnt_zero), (m_ar == 0) ? 1 : 0);
`else
    check_eq("cnt_zero", int'(cnt_zero), 0);
`endif
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic cycle();
    int a;
    #1;
    check_outs();
    a = model_a();
    if (!fe) begin
      if (pup) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(m_upc);
        else m_err = 1;
      end else begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else m_err = 1;
      end
    end
    if (!re) m_ar = int'(r);
`ifdef MSEQ_LOOP_COUNTER_EN
    else if (cnt_dec && m_ar > 0) m_ar = m_ar - 1;
`endif
    m_upc = (a + int'(c)) % (MAXV + 1);
    @(posedge cp);
    @(negedge cp);
  endtask

  task automatic idle();
    s = 2'd0; fe = 1'b1; pup = 1'b0; re = 1'b1; oe = 1'b0; zero = 1'b1;
    orin = '0; c = 1'b1; cnt_dec = 1'b0; d = '0; r = '0;
  endtask

  // Reset pulse asserted between clock edges; outputs must react without an edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outs();
    @(negedge cp);
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    #3;
    check_outs();
    check_eq("rst_y", int'(y), 0);
    check_eq("rst_empty", int'(empty), 1);
    @(negedge cp);
    rst = 1'b0;

    // Counting from zero
    repeat (3) cycle();
    #1 check_eq("count3_y", int'(y), 3);

    // Wrap through the incrementer
    s = 2'd3; d = 12'hFFF;
    #1 check_eq("wrap_cout", int'(cout), 1);
    cycle();
    s = 2'd0;
    #1 check_eq("wrap_y", int'(y), 0);
    cycle();

    zero = 1'b0; s = 2'd3; d = 12'h5A5;
    #1 check_eq("zero_y", int'(y), 0);
    cycle();
    zero = 1'b1; orin = 12'h00F; d = 12'h120;
    #1 check_eq("or_y", int'(y), 12'h12F);
    cycle();
    orin = '0; oe = 1'b1; s = 2'd0;
    cycle();
    oe = 1'b0;

    // Subroutine call and return
    s = 2'd3; d = 12'h00F;
    cycle();
    d = 12'h200; fe = 1'b0; pup = 1'b1;
    cycle();
    s = 2'd2; fe = 1'b1;
    #1 check_eq("push_top", int'(y), 12'h010);
    fe = 1'b0; pup = 1'b0;
    #1 check_eq("ret_y", int'(y), 12'h010);
    cycle();
    idle();
    #1 check_eq("after_ret_y", int'(y), 12'h011);
    check_eq("after_ret_empty", int'(empty), 1);
    cycle();

    // Overflow
    do_reset();
    fe = 1'b0; pup = 1'b1;
    repeat (5) cycle();
    #1 check_eq("five_full", int'(full), 1);
    cycle();
    fe = 1'b1; s = 2'd2;
    #1 check_eq("ovf_err", int'(err), 1);
    check_eq("ovf_top", int'(y), 4);
    cycle();

    // Underflow
    do_reset();
    fe = 1'b0; pup = 1'b0;
    cycle();
    fe = 1'b1;
    #1 check_eq("unf_err", int'(err), 1);
    check_eq("unf_empty", int'(empty), 1);
    cycle();

    // Address register load and hold
    r = 12'h0AB; re = 1'b0;
    cycle();
    re = 1'b1; r = 12'h123; s = 2'd1;
    #1 check_eq("ar_hold", int'(y), 12'h0AB);
    cycle();
    cycle();

    // Loop counter
    r = 12'h003; re = 1'b0;
    cycle();
    re = 1'b1; cnt_dec = 1'b1;
    repeat (3) cycle();
`ifdef MSEQ_LOOP_COUNTER_EN
    #1 check_eq("loop_zero", int'(cnt_zero), 1);
`endif
    cycle();
`ifdef MSEQ_LOOP_COUNTER_EN
    #1 check_eq("loop_sat", int'(y), 0);
`endif
    re = 1'b0; r = 12'h055;
    cycle();
    re = 1'b1; cnt_dec = 1'b0;
    #1 check_eq("load_wins", int'(y), 12'h055);
    cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      d       = WIDTH'($urandom);
      r       = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 4));
      orin    = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : '0;
      s       = 2'($urandom_range(0, 3));
      fe      = 1'($urandom_range(0, 1));
      pup     = 1'($urandom_range(0, 1));
      re      = ($urandom_range(0, 3) != 0);
      oe      = ($urandom_range(0, 7) == 0);
      zero    = ($urandom_range(0, 7) != 0);
      c       = 1'($urandom_range(0, 1));
      cnt_dec = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
